fetch_queue: RTL and testbench

//   Decoupling FIFO between the instruction fetch stage and the decode stage.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_queue.sv | 82 ++++++++
 tb/tb_fetch_queue.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types and constants.
// Holds the fetch packet type carried from the fetch stage to the decode stage.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling FIFO with valid/ready on both sides and a redirect flush.
// Head entry is read combinationally and masked to a NOP packet when the queue is empty.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = riscv_pkg::XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq_valid,
    output logic                       enq_ready,
    input  logic [XLEN-1:0]            enq_pc,
    input  logic [XLEN-1:0]            enq_pc_plus_4,
    input  logic [XLEN-1:0]            enq_instr,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [XLEN-1:0]            deq_pc,
    output logic [XLEN-1:0]            deq_pc_plus_4,
    output logic [XLEN-1:0]            deq_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_pkt_t mem [DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          push, pop, wr_en;
    fetch_pkt_t    head;

    assign enq_ready = (count != CW'(DEPTH));
    assign deq_valid = (count != '0);
    assign push      = enq_valid & enq_ready;
    assign pop       = deq_valid & deq_ready;
    // A flushed or reset cycle must not leave the dropped packet in storage either.
    assign wr_en     = push & ~flush & ~rst;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset; the empty mask hides stale entries.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr].pc        <= enq_pc;
            mem[wr_ptr].pc_plus_4 <= enq_pc_plus_4;
            mem[wr_ptr].instr     <= enq_instr;
        end
    end

    assign head          = mem[rd_ptr];
    assign deq_pc        = deq_valid ? head.pc        : '0;
    assign deq_pc_plus_4 = deq_valid ? head.pc_plus_4 : '0;
    assign deq_instr     = deq_valid ? head.instr     : XLEN'(NOP_INSTR);

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(enq_valid && enq_ready && count == CW'(DEPTH)))
                else $error("fetch_queue: push while full");
            assert (count <= CW'(DEPTH))
                else $error("fetch_queue: count overflow");
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 4).
// Inputs change 1ns after the rising edge; outputs are checked in the same window.
module tb_fetch_queue;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, flush, enq_valid, deq_ready;
    logic        enq_ready, deq_valid;
    logic [31:0] enq_pc, enq_pc_plus_4, enq_instr;
    logic [31:0] deq_pc, deq_pc_plus_4, deq_instr;
    logic [2:0]  count;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_pc(enq_pc), .enq_pc_plus_4(enq_pc_plus_4), .enq_instr(enq_instr),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_pc(deq_pc), .deq_pc_plus_4(deq_pc_plus_4), .deq_instr(deq_instr),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc);
        enq_valid     = v;
        enq_pc        = pc;
        enq_pc_plus_4 = pc + 32'd4;
        enq_instr     = instr_of(pc);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, ".pc"},    deq_pc,        pc);
        chk({tag, ".pc4"},   deq_pc_plus_4, pc + 32'd4);
        chk({tag, ".instr"}, deq_instr,     instr_of(pc));
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] nxt;
        logic        dr_pat [10];
        int          mcnt;
        logic        mpush, mpop;

        dr_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        rst = 1'b1; flush = 1'b0; deq_ready = 1'b0;
        drive(1'b1, 32'h55);

        // 1. reset held two cycles with enq_valid high
        step(); step();
        chk("rst.count", 32'(count), 0);
        chk("rst.deq_valid", 32'(deq_valid), 0);
        chk("rst.deq_instr", deq_instr, 32'h13);
        chk("rst.enq_ready", 32'(enq_ready), 1);
        chk("rst.deq_pc", deq_pc, 0);
        rst = 1'b0;
        drive(1'b0, 32'h0);

        // 2. fill then drain
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 * i));
            if (i == 0) chk("fill.no_bypass", 32'(deq_valid), 0);
            step();
        end
        drive(1'b0, 32'h0);
        chk("fill.enq_ready", 32'(enq_ready), 0);
        chk("fill.count", 32'(count), 4);
        deq_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk_head($sformatf("drain%0d", i), 32'(4 * i));
            step();
        end
        deq_ready = 1'b0;
        chk("drain.deq_valid", 32'(deq_valid), 0);
        chk("drain.deq_instr", deq_instr, 32'h13);
        chk("drain.deq_pc4", deq_pc_plus_4, 0);

        // 3. streaming
        drive(1'b1, 32'h100);
        deq_ready = 1'b1;
        step();
        for (int n = 1; n <= 5; n++) begin
            drive(1'b1, 32'h100 + 32'(4 * n));
            chk("stream.count", 32'(count), 1);
            chk("stream.deq_pc", deq_pc, 32'h100 + 32'(4 * (n - 1)));
            step();
        end
        drive(1'b0, 32'h0);
        step();
        chk("stream.empty", 32'(count), 0);
        deq_ready = 1'b0;

        // 4. flush race with push and pop
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h180 + 32'(4 * i));
            step();
        end
        chk("flush.pre_count", 32'(count), 3);
        flush = 1'b1; deq_ready = 1'b1;
        drive(1'b1, 32'h200);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0);
        chk("flush.count", 32'(count), 0);
        chk("flush.deq_valid", 32'(deq_valid), 0);
        step();
        chk("flush.stays_empty", 32'(deq_valid), 0);
        chk("flush.no_0x200", deq_pc, 0);
        deq_ready = 1'b0;

        // 5. wrap-around against a scoreboard; fetch holds pc until accepted
        mcnt = 0;
        nxt  = 32'h300;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, nxt);
            deq_ready = dr_pat[c];
            mpush = (mcnt != DEPTH);
            mpop  = (mcnt != 0) && dr_pat[c];
            chk("wrap.enq_ready", 32'(enq_ready), 32'(mpush));
            chk("wrap.count", 32'(count), 32'(mcnt));
            if (mpop) begin
                chk("wrap.deq_pc", deq_pc, q[0]);
                void'(q.pop_front());
            end
            if (mpush) begin
                q.push_back(nxt);
                nxt = nxt + 32'd4;
            end
            mcnt = mcnt + int'(mpush) - int'(mpop);
            step();
        end
        drive(1'b0, 32'h0);
        deq_ready = 1'b1;
        for (int b = 0; b < 8 && q.size() != 0; b++) begin
            chk_head("wrap.drain", q[0]);
            void'(q.pop_front());
            step();
        end
        chk("wrap.sb_empty", 32'(q.size()), 0);
        chk("wrap.dut_empty", 32'(deq_valid), 0);
        deq_ready = 1'b0;

        // 6. full with pop: push rejected first, accepted next cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h3C0 + 32'(4 * i));
            step();
        end
        drive(1'b1, 32'h400);
        deq_ready = 1'b1;
        chk("full.enq_ready", 32'(enq_ready), 0);
        step();
        chk("full.count_after_pop", 32'(count), 3);
        chk("full.enq_ready_after", 32'(enq_ready), 1);
        step();
        drive(1'b0, 32'h0);
        deq_ready = 1'b0;
        chk("full.count_pushpop", 32'(count), 3);
        chk_head("full.head", 32'h3C8);
        deq_ready = 1'b1;
        step(); step();
        chk_head("full.tail", 32'h400);
        step();
        chk("full.final_empty", 32'(deq_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
